// File: rtl/mem_bus_arbiter.sv
// Arbitrates one word-addressed memory bus between instruction fetch and the data port.
// Optional grant timeout with bus-error abort is enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 30,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_i_re,
  input  logic [ADDR_WIDTH-1:0] i_i_adr,
  output logic [31:0]           o_i_dout,
  output logic                  o_i_ack,
  input  logic                  i_d_re,
  input  logic                  i_d_we,
  input  logic [ADDR_WIDTH-1:0] i_d_adr,
  input  logic [3:0]            i_d_sel,
  input  logic [31:0]           i_d_din,
  output logic [31:0]           o_d_dout,
  output logic                  o_d_ack,
  output logic [ADDR_WIDTH-1:0] o_mem_adr,
  output logic [3:0]            o_mem_sel,
  output logic                  o_mem_we,
  output logic                  o_mem_re,
  output logic [31:0]           o_mem_din,
  input  logic [31:0]           i_mem_dout,
  input  logic                  i_mem_ack,
  output logic                  o_bus_err
);

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            d_req;
  logic            timeout_hit;

  assign d_req = i_d_re | i_d_we;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;

  assign timeout_hit = (state_q != IDLE) && !i_mem_ack && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Counts grant cycles already spent; zero in the first cycle of every grant.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)                               to_cnt_q <= '0;
    else if (state_q == IDLE || state_d == IDLE) to_cnt_q <= '0;
    else                                         to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (d_req && !(i_i_re && starve_q == SW'(STARVE_LIMIT))) begin
          state_d = GNT_D;
          if (!i_i_re)                             starve_d = '0;
          else if (starve_q != SW'(STARVE_LIMIT))  starve_d = starve_q + 1'b1;
        end else if (i_i_re) begin
          state_d  = GNT_I;
          starve_d = '0;
        end
      end
      GNT_D:   if (i_mem_ack || !d_req || timeout_hit) state_d = IDLE;
      GNT_I:   if (i_mem_ack || !i_i_re || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_mem_adr = '0;
    o_mem_sel = '0;
    o_mem_we  = 1'b0;
    o_mem_re  = 1'b0;
    o_mem_din = '0;
    o_d_ack   = 1'b0;
    o_i_ack   = 1'b0;
    case (state_q)
      GNT_D: begin
        o_mem_adr = i_d_adr;
        o_mem_sel = i_d_sel;
        o_mem_we  = i_d_we;
        o_mem_re  = i_d_re & ~i_d_we;
        o_mem_din = i_d_din;
        o_d_ack   = i_mem_ack | timeout_hit;
      end
      GNT_I: begin
        o_mem_adr = i_i_adr;
        o_mem_sel = 4'hF;
        o_mem_re  = 1'b1;
        o_i_ack   = i_mem_ack | timeout_hit;
      end
      default: ;
    endcase
  end

  // An aborted transfer returns zero data instead of whatever the bus floats.
  assign o_d_dout  = timeout_hit ? '0 : i_mem_dout;
  assign o_i_dout  = timeout_hit ? '0 : i_mem_dout;
  assign o_bus_err = timeout_hit;

endmodule
